// File: rtl/d_reg_pipeline.sv
// d_reg_pipeline: elastic chain of DEPTH WIDTH-bit register stages with per-stage
// valid bits and valid/ready flow control; empty stages absorb bubbles under stall.
// Latency DEPTH cycles empty-to-output; throughput 1 word/cycle; ready is combinational.
// Optional feature: define D_REG_PIPELINE_PARITY_EN to carry an even-parity bit per
// stage and flag mismatches on the output stage (parity_err); otherwise parity_err = 0.
// Ports: clock, reset (async, active-high), flush (sync clear of valids),
//        in_valid/in_data/in_ready (upstream), out_valid/out_data/out_ready (downstream),
//        occupancy (registered count of valid stages), parity_err.
module d_reg_pipeline #(
  parameter int unsigned             WIDTH       = 8,
  parameter int unsigned             DEPTH       = 4,
  parameter logic [WIDTH-1:0]        RESET_VALUE = '0,
  localparam int unsigned            OCC_W       = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occupancy,
  output logic             parity_err
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_next;
  logic [WIDTH-1:0] d     [DEPTH];
  logic [WIDTH-1:0] src_d [DEPTH];
  logic [DEPTH-1:0] src_v;
  logic [DEPTH:0]   rdy;
  logic [OCC_W-1:0] occ_next;

  // Ready ripples back from the output: a stage can take data if it is empty
  // or if the stage after it is moving this cycle.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy[i] = ~v[i] | rdy[i+1];
    end
  end

  // Each stage's source is the previous stage; stage 0 is fed from the input port.
  always_comb begin
    src_v[0] = in_valid;
    src_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = v[i-1];
      src_d[i] = d[i-1];
    end
  end

  always_comb begin
    v_next   = v;
    occ_next = '0;
    if (flush) begin
      v_next = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) v_next[i] = src_v[i];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      occ_next = occ_next + OCC_W'(v_next[i]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v         <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= RESET_VALUE;
    end else begin
      v         <= v_next;
      occupancy <= occ_next;
      // Data only moves with a valid word; flushed or empty slots keep stale data stable.
      for (int i = 0; i < DEPTH; i++) begin
        if (!flush && rdy[i] && src_v[i]) d[i] <= src_d[i];
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

`ifdef D_REG_PIPELINE_PARITY_EN
  logic [DEPTH-1:0] p;
  logic [DEPTH-1:0] src_p;

  always_comb begin
    src_p[0] = ^in_data;
    for (int i = 1; i < DEPTH; i++) src_p[i] = p[i-1];
  end

  // Parity bit travels in lockstep with its stage's data register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p <= {DEPTH{^RESET_VALUE}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!flush && rdy[i] && src_v[i]) p[i] <= src_p[i];
      end
    end
  end

  assign parity_err = v[DEPTH-1] & ((^d[DEPTH-1]) != p[DEPTH-1]);
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_d_reg_pipeline.sv
// tb_d_reg_pipeline: scoreboard bench for d_reg_pipeline (WIDTH=8, DEPTH=4).
// Accepted input words are queued; each output transfer pops and compares.
// Ports of the DUT are all connected; clock period 10.
module tb_d_reg_pipeline;

  localparam int unsigned     WIDTH = 8;
  localparam int unsigned     DEPTH = 4;
  localparam logic [7:0]      RV    = 8'h5A;

  logic       clock = 1'b0;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] occupancy;
  logic       parity_err;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb_q[$];

  always #5 clock = ~clock;

  d_reg_pipeline #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VALUE(RV)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .occupancy  (occupancy),
    .parity_err (parity_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge with inputs already driven. Records the
  // handshakes that will happen at the coming rising edge, then waits for the
  // next falling edge.
  task automatic tick();
    #2;
    if (in_valid && in_ready && !flush) sb_q.push_back(in_data);
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) check("sb_nonempty", 32'(sb_q.size()), 32'd1);
      else check("out_data", 32'(out_data), 32'(sb_q.pop_front()));
    end
    @(negedge clock);
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((out_valid || occupancy != 0) && n < 50) begin
      tick();
      n++;
    end
    check("drain_done", 32'(n < 50), 32'd1);
    check("drain_sb_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int lat;
    int acc;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clock);
    // Reset values
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'(RV));
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    reset = 1'b0;

    // Latency: single word, out_ready high
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    lat = 0;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      if (out_valid) lat = k;
      tick();
    end
    check("latency", 32'(lat), 32'(DEPTH));
    check("lat_occ_zero", 32'(occupancy), 32'd0);
    check("lat_sb_empty", 32'(sb_q.size()), 32'd0);

    // Backpressure fill: four fit, fifth is refused
    out_ready = 1'b0;
    for (int w = 1; w <= 4; w++) begin
      in_valid = 1'b1; in_data = 8'(w);
      check("fill_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_data = 8'h05;
    #1;
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_occ", 32'(occupancy), 32'd4);
    tick();
    out_ready = 1'b1;
    #1;
    check("full_passthru_ready", 32'(in_ready), 32'd1);
    acc = 5;
    for (int n = 0; n < 20 && acc <= 6; n++) begin
      in_data = 8'(acc);
      if (in_ready) acc++;
      tick();
    end
    check("fill_all_accepted", 32'(acc), 32'd7);
    check("full_steady_occ", 32'(occupancy), 32'd4);
    drain();

    // Streaming 20 random words back to back
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom_range(0, 255));
      check("stream_in_ready", 32'(in_ready), 32'd1);
      if (i >= DEPTH) check("stream_occ", 32'(occupancy), 32'd4);
      tick();
    end
    drain();

    // Flush with occupancy 3 and a word offered
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h30 + i);
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("preflush_occ", 32'(occupancy), 32'd3);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_occ", 32'(occupancy), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    sb_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("flush_sb_empty", 32'(sb_q.size()), 32'd0);

    // Reset mid-stream, asserted between edges
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h70 + i);
      tick();
    end
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("midrst_occ", 32'(occupancy), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'(RV));
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    sb_q.delete();

`ifdef D_REG_PIPELINE_PARITY_EN
    // Parity: a word parked at the output, then one bit corrupted in place
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h3B;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) tick();
    check("par_out_valid", 32'(out_valid), 32'd1);
    check("par_ok", 32'(parity_err), 32'd0);
    dut.d[DEPTH-1] = dut.d[DEPTH-1] ^ 8'h01;
    #1;
    check("par_err", 32'(parity_err), 32'd1);
    sb_q.delete();
    sb_q.push_back(8'h3A);
    drain();
    check("par_idle", 32'(parity_err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
